// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the sequencer state encoding and the default drain length.
package pipe_ctrl_pkg;

    localparam int REG_AW           = 5;
    localparam int DRAIN_CYCLES_DEF = 3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LSU_WAIT = 2'd1,
        ST_DRAIN    = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the hazard controller and the pipeline datapath.
// master = hazard controller side, slave = pipeline/LSU side.
interface pipe_hazard_ctrl_if;

    logic [pipe_ctrl_pkg::REG_AW-1:0] id_rs1;
    logic [pipe_ctrl_pkg::REG_AW-1:0] id_rs2;
    logic                             id_rs1_used;
    logic                             id_rs2_used;
    logic                             id_serialize;
    logic [pipe_ctrl_pkg::REG_AW-1:0] ex_rd;
    logic                             ex_mem_ren;
    logic                             ex_redirect;
    logic                             mem_access;
    logic                             lsu_rsp_valid;

    logic                             lsu_req;
    logic                             pc_stall;
    logic                             stall_ifid;
    logic                             stall_idex;
    logic                             stall_exmem;
    logic                             stall_memwb;
    logic                             flush_ifid;
    logic                             flush_idex;
    logic                             flush_exmem;
    logic                             flush_memwb;

    modport master (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_serialize,
        input  ex_rd, ex_mem_ren, ex_redirect, mem_access, lsu_rsp_valid,
        output lsu_req, pc_stall,
        output stall_ifid, stall_idex, stall_exmem, stall_memwb,
        output flush_ifid, flush_idex, flush_exmem, flush_memwb
    );

    modport slave (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_serialize,
        output ex_rd, ex_mem_ren, ex_redirect, mem_access, lsu_rsp_valid,
        input  lsu_req, pc_stall,
        input  stall_ifid, stall_idex, stall_exmem, stall_memwb,
        input  flush_ifid, flush_idex, flush_exmem, flush_memwb
    );

endinterface

// File: rtl/pipe_loaduse_detect.sv
// Combinational load-use hazard compare between the EX load and the ID sources.
// x0 is never a real dependency, so a load to x0 never interlocks.
module pipe_loaduse_detect
    import pipe_ctrl_pkg::*;
(
    input  logic              ex_mem_ren,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    output logic              load_use
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = id_rs1_used && (id_rs1 == ex_rd);
    assign rs2_hit  = id_rs2_used && (id_rs2 == ex_rd);
    assign load_use = ex_mem_ren && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline (load-use, redirect, LSU wait, drain).
// Optional build macro PIPE_PERF_CNT_EN adds saturating perf counters for stall/flush cycles.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int PERF_W       = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_hazard_ctrl_if.master    hz
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]     perf_lsu_stall,
    output logic [PERF_W-1:0]     perf_lu_stall,
    output logic [PERF_W-1:0]     perf_flush
`endif
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
    logic             drained_q, drained_d;

    logic load_use;
    logic lsu_req;
    logic mem_busy;
    logic redirect;
    logic lu_hit;
    logic drain_hold;
    logic drain_done;

    logic pc_stall;
    logic stall_ifid, stall_idex, stall_exmem;
    logic flush_ifid, flush_idex, flush_memwb;

    pipe_loaduse_detect u_loaduse (
        .ex_mem_ren  (hz.ex_mem_ren),
        .ex_rd       (hz.ex_rd),
        .id_rs1      (hz.id_rs1),
        .id_rs2      (hz.id_rs2),
        .id_rs1_used (hz.id_rs1_used),
        .id_rs2_used (hz.id_rs2_used),
        .load_use    (load_use)
    );

    // Every hazard term is gated by rst so all outputs drop in the reset cycle itself.
    assign lsu_req    = !rst && ((state_q == ST_LSU_WAIT) || hz.mem_access);
    assign mem_busy   = lsu_req && !hz.lsu_rsp_valid;
    assign redirect   = !rst && hz.ex_redirect && !mem_busy;
    assign lu_hit     = !rst && load_use && !mem_busy && !redirect;
    assign drain_hold = !rst && (state_q == ST_DRAIN) && !mem_busy && !redirect;
    assign drain_done = drain_hold && (drain_cnt_q == CNT_LAST);

    // NOTE: every signal written in an always_comb gets a default first, otherwise
    // a path that skips the assignment infers a latch.
    always_comb begin
        pc_stall    = 1'b0;
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        stall_exmem = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_memwb = 1'b0;
        if (mem_busy) begin
            pc_stall    = 1'b1;
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            stall_exmem = 1'b1;
            flush_memwb = 1'b1;
        end else if (redirect) begin
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
        end else if (lu_hit || drain_hold) begin
            pc_stall    = 1'b1;
            stall_ifid  = 1'b1;
            flush_idex  = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        drained_d   = drained_q;
        unique case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    state_d = ST_LSU_WAIT;
                end else if (hz.id_serialize && !drained_q && !redirect) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_LSU_WAIT: begin
                if (hz.lsu_rsp_valid) state_d = ST_RUN;
            end
            ST_DRAIN: begin
                // The count only advances in cycles where the LSU is not holding the pipe.
                if (redirect) begin
                    state_d = ST_RUN;
                end else if (drain_done) begin
                    state_d = ST_RUN;
                end else if (drain_hold) begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // The drained flag exempts the serialising instr from re-draining until it leaves ID.
        if (drain_done) begin
            drained_d = 1'b1;
        end else if (flush_ifid || !stall_ifid) begin
            drained_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            drain_cnt_q <= '0;
            drained_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            drained_q   <= drained_d;
        end
    end

    assign hz.lsu_req     = lsu_req;
    assign hz.pc_stall    = pc_stall;
    assign hz.stall_ifid  = stall_ifid;
    assign hz.stall_idex  = stall_idex;
    assign hz.stall_exmem = stall_exmem;
    assign hz.stall_memwb = 1'b0;
    assign hz.flush_ifid  = flush_ifid;
    assign hz.flush_idex  = flush_idex;
    assign hz.flush_exmem = 1'b0;
    assign hz.flush_memwb = flush_memwb;

`ifdef PIPE_PERF_CNT_EN
    logic [PERF_W-1:0] perf_lsu_q, perf_lsu_d;
    logic [PERF_W-1:0] perf_lu_q,  perf_lu_d;
    logic [PERF_W-1:0] perf_fl_q,  perf_fl_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        perf_lsu_d = perf_lsu_q;
        perf_lu_d  = perf_lu_q;
        perf_fl_d  = perf_fl_q;
        if (mem_busy && !(&perf_lsu_q)) perf_lsu_d = perf_lsu_q + 1'b1;
        if (lu_hit   && !(&perf_lu_q))  perf_lu_d  = perf_lu_q + 1'b1;
        if (redirect && !(&perf_fl_q))  perf_fl_d  = perf_fl_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lsu_q <= '0;
            perf_lu_q  <= '0;
            perf_fl_q  <= '0;
        end else begin
            perf_lsu_q <= perf_lsu_d;
            perf_lu_q  <= perf_lu_d;
            perf_fl_q  <= perf_fl_d;
        end
    end

    assign perf_lsu_stall = perf_lsu_q;
    assign perf_lu_stall  = perf_lu_q;
    assign perf_flush     = perf_fl_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random traffic
// compared each cycle against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int DRAIN_CYCLES = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz_if ();

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] perf_lsu_stall, perf_lu_stall, perf_flush;
`endif

    pipe_hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .hz             (hz_if)
`ifdef PIPE_PERF_CNT_EN
        ,
        .perf_lsu_stall (perf_lsu_stall),
        .perf_lu_stall  (perf_lu_stall),
        .perf_flush     (perf_flush)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: outstanding LSU access, cycles left in the drain, drain-exemption flag.
    bit m_pending   = 1'b0;
    int m_drain_left = 0;
    bit m_drained   = 1'b0;
    int m_lsu_cnt = 0, m_lu_cnt = 0, m_fl_cnt = 0;

    // {lsu_req, pc_stall, stall_ifid, stall_idex, stall_exmem, stall_memwb,
    //  flush_ifid, flush_idex, flush_exmem, flush_memwb}
    logic [9:0] last_out;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [9:0] dut_out();
        return {hz_if.lsu_req, hz_if.pc_stall, hz_if.stall_ifid, hz_if.stall_idex,
                hz_if.stall_exmem, hz_if.stall_memwb, hz_if.flush_ifid, hz_if.flush_idex,
                hz_if.flush_exmem, hz_if.flush_memwb};
    endfunction

    // One clock cycle: drive at the falling edge, check 1 ns later, advance the model.
    task automatic cycle(input logic r, input logic mem, input logic rsp, input logic rdr,
                         input logic ser, input logic ren, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2);
        bit req, busy, redir, lu, in_drain, hold;
        logic [9:0] exp;
        rst                 = r;
        hz_if.mem_access    = mem;
        hz_if.lsu_rsp_valid = rsp;
        hz_if.ex_redirect   = rdr;
        hz_if.id_serialize  = ser;
        hz_if.ex_mem_ren    = ren;
        hz_if.ex_rd         = rd;
        hz_if.id_rs1        = rs1;
        hz_if.id_rs2        = rs2;
        hz_if.id_rs1_used   = u1;
        hz_if.id_rs2_used   = u2;
        #1;
        req      = !r && (m_pending || mem);
        busy     = req && !rsp;
        redir    = !r && rdr && !busy;
        lu       = !r && ren && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        in_drain = (m_drain_left > 0);
        hold     = !r && !busy && !redir && (lu || in_drain);
        exp = {req, busy || hold, busy || hold, busy, busy, 1'b0,
               redir, redir || hold, 1'b0, busy};
        last_out = dut_out();
        check("outs", {22'd0, last_out}, {22'd0, exp});

        if (r) begin
            m_pending = 0; m_drain_left = 0; m_drained = 0;
            m_lsu_cnt = 0; m_lu_cnt = 0; m_fl_cnt = 0;
        end else begin
            m_lsu_cnt += int'(busy);
            m_lu_cnt  += int'(lu && !busy && !redir);
            m_fl_cnt  += int'(redir);
            if (!busy) begin
                if (in_drain) begin
                    if (redir) begin
                        m_drain_left = 0;
                        m_drained    = 0;
                    end else begin
                        m_drain_left--;
                        if (m_drain_left == 0) m_drained = 1;
                    end
                end else begin
                    if (!m_pending && ser && !m_drained && !redir) m_drain_left = DRAIN_CYCLES;
                    if (!hold) m_drained = 0;
                end
            end
            m_pending = busy;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    int cnt_req, cnt_stall, cnt_mwb, cnt_fidex;

    initial begin
        hz_if.mem_access = 0; hz_if.lsu_rsp_valid = 0; hz_if.ex_redirect = 0;
        hz_if.id_serialize = 0; hz_if.ex_mem_ren = 0; hz_if.ex_rd = '0;
        hz_if.id_rs1 = '0; hz_if.id_rs2 = '0; hz_if.id_rs1_used = 0; hz_if.id_rs2_used = 0;
        @(negedge clk);

        // Reset with every hazard input active: all outputs must stay low.
        cycle(1, 1, 0, 1, 1, 1, 5'd5, 5'd5, 5'd5, 1, 1);
        check("reset_outs", {22'd0, last_out}, 32'd0);
        idle();

        // Load-use on x5, then the same pattern on x0.
        cycle(0, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd1, 1, 1);
        check("lu_x5_pc_stall", {31'd0, last_out[8]}, 32'd1);
        idle();
        check("lu_one_cycle", {31'd0, last_out[8]}, 32'd0);
        cycle(0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
        check("lu_x0_no_stall", {31'd0, last_out[8]}, 32'd0);

        // Response three cycles after the request.
        cnt_req = 0; cnt_stall = 0; cnt_mwb = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, (i == 3), 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
            cnt_req   += int'(last_out[9]);
            cnt_stall += int'(last_out[8]);
            cnt_mwb   += int'(last_out[0]);
        end
        check("lsu3_req_cycles", cnt_req, 32'd4);
        check("lsu3_stall_cycles", cnt_stall, 32'd3);
        check("lsu3_flush_memwb", cnt_mwb, 32'd3);
        idle();

        // Zero-wait response.
        cycle(0, 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("lsu0_no_stall", {31'd0, last_out[8]}, 32'd0);
        idle();

        // Redirect with simultaneous load-use.
        cycle(0, 0, 0, 1, 0, 1, 5'd7, 5'd7, 5'd0, 1, 0);
        check("redir_lu_flags", {22'd0, last_out}, {22'd0, 10'b0000001100});
        idle();

        // Redirect held across an LSU wait, acted on in the release cycle.
        cycle(0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("redir_in_wait_masked", {31'd0, last_out[3]}, 32'd0);
        cycle(0, 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        cycle(0, 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("redir_on_release", {30'd0, last_out[3:2]}, 32'd3);
        idle();

        // Serialising instruction: drains once, advances once, no re-drain.
        cnt_fidex = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
            cnt_fidex += int'(last_out[2]);
        end
        check("drain_flush_idex_cycles", cnt_fidex, DRAIN_CYCLES);
        check("drain_advance_no_stall", {31'd0, last_out[7]}, 32'd0);
        idle();

        // Reset while waiting on the LSU.
        cycle(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        check("rst_in_wait_same_cycle", {22'd0, last_out}, 32'd0);
        idle();
        check("rst_in_wait_next", {22'd0, last_out}, 32'd0);

`ifdef PIPE_PERF_CNT_EN
        begin
            logic [31:0] base;
            base = perf_lsu_stall;
            for (int i = 0; i < 6; i++)
                cycle(0, 1, (i == 5), 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
            check("perf_lsu_5", perf_lsu_stall - base, 32'd5);
        end
`endif

        // Random traffic; the LSU access stays presented while outstanding.
        for (int i = 0; i < 3000; i++) begin
            logic r, mem;
            r   = ($urandom_range(0, 199) == 0);
            mem = m_pending ? 1'b1 : ($urandom_range(0, 9) < 3);
            cycle(r, mem, ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 4),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
        end

`ifdef PIPE_PERF_CNT_EN
        check("perf_lsu_total", perf_lsu_stall, m_lsu_cnt);
        check("perf_lu_total", perf_lu_stall, m_lu_cnt);
        check("perf_flush_total", perf_flush, m_fl_cnt);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
